// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_operand_stage: ID->EX pipeline register with immediate decode      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module id_ex_operand_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ID,
  input  logic [31:0] instr_ID,
  input  logic [31:0] pc_ID,
  input  logic [31:0] rdata1_ID,
  input  logic [31:0] rdata2_ID,
  input  logic        stall,
  input  logic        flush,
  output logic        valid_EX,
  output logic [31:0] instr_EX,
  output logic [31:0] pc_EX,
  output logic [31:0] R1_EX,
  output logic [31:0] R2_EX,
  output logic [31:0] ImmExt_EX,
  output logic        Bsel,
  output logic [4:0]  rs1_EX,
  output logic [4:0]  rs2_EX,
  output logic [4:0]  rd_EX,
  output logic        illegal_EX
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;

  logic [31:0] w_imm;
  logic        w_bsel;
  logic        w_illegal;
  logic        w_no_wb;
  logic        w_bubble;

  always_comb begin
    w_imm     = '0;
    w_bsel    = 1'b0;
    w_illegal = 1'b0;
    w_no_wb   = 1'b0;
    case (instr_ID[6:0])
      c_OP_LOAD, c_OP_IMM, c_OP_JALR: begin
        w_imm  = {{20{instr_ID[31]}}, instr_ID[31:20]};
        w_bsel = 1'b1;
      end
      c_OP_STORE: begin
        w_imm   = {{20{instr_ID[31]}}, instr_ID[31:25], instr_ID[11:7]};
        w_bsel  = 1'b1;
        w_no_wb = 1'b1;
      end
      c_OP_BRANCH: begin
        w_imm   = {{20{instr_ID[31]}}, instr_ID[7], instr_ID[30:25],
                   instr_ID[11:8], 1'b0};
        w_no_wb = 1'b1;
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_imm  = {instr_ID[31:12], 12'h000};
        w_bsel = 1'b1;
      end
      c_OP_JAL: begin
        w_imm  = {{12{instr_ID[31]}}, instr_ID[19:12], instr_ID[20],
                  instr_ID[30:21], 1'b0};
        w_bsel = 1'b1;
      end
      c_OP_REG: ;
      default: w_illegal = 1'b1;
    endcase
  end

  // An empty ID slot that is not held by a stall becomes a bubble, exactly as a flush does.
  assign w_bubble = flush | (~stall & ~valid_ID);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_r1;
  logic [31:0] r_r2;
  logic [31:0] r_imm;
  logic        r_bsel;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic        r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_INSTR;
      r_pc      <= rst_n ? pc_ID : 32'h0;
      r_r1      <= '0;
      r_r2      <= '0;
      r_imm     <= '0;
      r_bsel    <= 1'b0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else if (!stall) begin
      r_valid   <= valid_ID;
      r_instr   <= instr_ID;
      r_pc      <= pc_ID;
      r_r1      <= rdata1_ID;
      r_r2      <= rdata2_ID;
      r_imm     <= w_imm;
      r_bsel    <= w_bsel;
      r_rs1     <= instr_ID[19:15];
      r_rs2     <= instr_ID[24:20];
      r_rd      <= w_no_wb ? 5'd0 : instr_ID[11:7];
      r_illegal <= w_illegal;
    end
  end

  assign valid_EX   = r_valid;
  assign instr_EX   = r_instr;
  assign pc_EX      = r_pc;
  assign R1_EX      = r_r1;
  assign R2_EX      = r_r2;
  assign ImmExt_EX  = r_imm;
  assign Bsel       = r_bsel;
  assign rs1_EX     = r_rs1;
  assign rs2_EX     = r_rs2;
  assign rd_EX      = r_rd;
  assign illegal_EX = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_ex_operand_stage: randomized + directed bench for ID->EX register   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic        bsel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ID;
  logic [31:0] instr_ID, pc_ID, rdata1_ID, rdata2_ID;
  logic        stall, flush;
  logic        valid_EX, Bsel, illegal_EX;
  logic [31:0] instr_EX, pc_EX, R1_EX, R2_EX, ImmExt_EX;
  logic [4:0]  rs1_EX, rs2_EX, rd_EX;

  int errors = 0;
  int checks = 0;
  ex_t exp_s;
  ex_t act;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID), .instr_ID(instr_ID),
    .pc_ID(pc_ID), .rdata1_ID(rdata1_ID), .rdata2_ID(rdata2_ID),
    .stall(stall), .flush(flush), .valid_EX(valid_EX), .instr_EX(instr_EX),
    .pc_EX(pc_EX), .R1_EX(R1_EX), .R2_EX(R2_EX), .ImmExt_EX(ImmExt_EX),
    .Bsel(Bsel), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
    .illegal_EX(illegal_EX)
  );

  assign act = {valid_EX, instr_EX, pc_EX, R1_EX, R2_EX, ImmExt_EX, Bsel,
                rs1_EX, rs2_EX, rd_EX, illegal_EX};

  // Format class: 0=R 1=I 2=S 3=B 4=U 5=J 6=unsupported
  function automatic int fmt(input logic [31:0] ins);
    case (int'(ins[6:0]))
      3, 19, 103: return 1;
      35:         return 2;
      99:         return 3;
      55, 23:     return 4;
      111:        return 5;
      51:         return 0;
      default:    return 6;
    endcase
  endfunction

  // Immediates built with signed arithmetic shifts rather than bit replication.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int s;
    int u;
    s = int'(ins);
    u = 0;
    case (fmt(ins))
      1: u = s >>> 20;
      2: u = ((s >>> 25) * 32) + int'(ins[11:7]);
      3: u = ((s >>> 31) * 4096) + int'(ins[7]) * 2048
             + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      4: u = int'(ins & 32'hFFFF_F000);
      5: u = ((s >>> 31) * 1048576) + int'(ins[19:12]) * 4096
             + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: u = 0;
    endcase
    return u;
  endfunction

  function automatic ex_t bubble(input logic [31:0] pc);
    ex_t b;
    b = '0;
    b.instr = 32'h0000_0013;
    b.pc = pc;
    return b;
  endfunction

  function automatic ex_t model(input ex_t cur, input logic v, input logic [31:0] ins,
                                input logic [31:0] pc, input logic [31:0] a,
                                input logic [31:0] b, input logic st, input logic fl);
    ex_t n;
    int f;
    if (fl || (!st && !v)) return bubble(pc);
    if (st) return cur;
    f = fmt(ins);
    n.valid   = 1'b1;
    n.instr   = ins;
    n.pc      = pc;
    n.r1      = a;
    n.r2      = b;
    n.imm     = ref_imm(ins);
    n.bsel    = (f == 1 || f == 2 || f == 4 || f == 5);
    n.rs1     = ins[19:15];
    n.rs2     = ins[24:20];
    n.rd      = (f == 2 || f == 3) ? 5'd0 : ins[11:7];
    n.illegal = (f == 6);
    return n;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
    valid_ID  = v;
    instr_ID  = ins;
    pc_ID     = pc;
    rdata1_ID = $urandom;
    rdata2_ID = $urandom;
    stall     = st;
    flush     = fl;
    exp_s = model(exp_s, v, ins, pc, rdata1_ID, rdata2_ID, st, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h1000, 1'b0, 1'b0);
    exp_s = bubble(32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act !== exp_s) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", act, exp_s);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi;
    drive(1'b1, 32'hFFF00093, 32'h0000_0040, 1'b0, 1'b0);
    checks++;
    if (ImmExt_EX !== 32'hFFFF_FFFF || Bsel !== 1'b1 || rd_EX !== 5'd1 || valid_EX !== 1'b1) begin
      errors++;
      $display("FAIL addi imm=%h bsel=%b rd=%0d valid=%b exp imm=ffffffff bsel=1 rd=1 valid=1",
               ImmExt_EX, Bsel, rd_EX, valid_EX);
    end
    checks++;
    if (act !== exp_s) begin
      errors++;
      $display("FAIL addi_all got=%h exp=%h", act, exp_s);
    end
  endtask

  task automatic test_branch_store;
    drive(1'b1, 32'hFE208EE3, 32'h0000_0044, 1'b0, 1'b0);
    checks++;
    if (ImmExt_EX !== 32'hFFFF_FFFC || Bsel !== 1'b0 || rd_EX !== 5'd0) begin
      errors++;
      $display("FAIL beq imm=%h bsel=%b rd=%0d exp imm=fffffffc bsel=0 rd=0", ImmExt_EX, Bsel, rd_EX);
    end
    drive(1'b1, 32'h00112223, 32'h0000_0048, 1'b0, 1'b0);
    checks++;
    if (ImmExt_EX !== 32'h4 || Bsel !== 1'b1 || rd_EX !== 5'd0) begin
      errors++;
      $display("FAIL sw imm=%h bsel=%b rd=%0d exp imm=4 bsel=1 rd=0", ImmExt_EX, Bsel, rd_EX);
    end
  endtask

  task automatic test_stall;
    ex_t held;
    drive(1'b1, 32'h002081B3, 32'h0000_0050, 1'b0, 1'b0);
    held = exp_s;
    checks++;
    if (Bsel !== 1'b0 || rd_EX !== 5'd3 || act !== held) begin
      errors++;
      $display("FAIL add_load got=%h exp=%h", act, held);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom | 32'h13, $urandom, 1'b1, 1'b0);
      checks++;
      if (act !== held) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d got=%h exp=%h", i, act, held);
      end
    end
  endtask

  task automatic test_flush_stall;
    drive(1'b1, 32'h123452B7, 32'h0000_0060, 1'b1, 1'b1);
    checks++;
    if (valid_EX !== 1'b0 || instr_EX !== 32'h13 || Bsel !== 1'b0 || ImmExt_EX !== 32'h0
        || act !== exp_s) begin
      errors++;
      $display("FAIL flush_stall got=%h exp=%h", act, exp_s);
    end
  endtask

  task automatic test_illegal;
    drive(1'b1, 32'hABCDE0FF, 32'h0000_0070, 1'b0, 1'b0);
    checks++;
    if (illegal_EX !== 1'b1 || ImmExt_EX !== 32'h0 || Bsel !== 1'b0 || valid_EX !== 1'b1) begin
      errors++;
      $display("FAIL illegal ill=%b imm=%h bsel=%b valid=%b exp ill=1 imm=0 bsel=0 valid=1",
               illegal_EX, ImmExt_EX, Bsel, valid_EX);
    end
    drive(1'b0, 32'h00A00513, 32'h0000_0074, 1'b0, 1'b0);
    checks++;
    if (act !== exp_s) begin
      errors++;
      $display("FAIL invalid_bubble got=%h exp=%h", act, exp_s);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'h00A00513, 32'h0000_0080, 1'b0, 1'b0);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_s = bubble(32'h0);
    checks++;
    if (valid_EX !== 1'b0 || pc_EX !== 32'h0 || ImmExt_EX !== 32'h0 || act !== exp_s) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", act, exp_s);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (act !== exp_s) begin
      errors++;
      $display("FAIL reset_over_flush got=%h exp=%h", act, exp_s);
    end
    #2;
    rst_n = 1'b1;
    drive(1'b1, 32'h7FF0006F, 32'h0000_0090, 1'b0, 1'b0);
    checks++;
    if (act !== exp_s) begin
      errors++;
      $display("FAIL post_reset_load got=%h exp=%h", act, exp_s);
    end
  endtask

  task automatic test_random;
    logic [6:0] ops [10];
    logic [31:0] ins;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      ins[6:0] = (i % 10 == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      drive($urandom_range(0, 99) < 85, ins, $urandom,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
      checks++;
      if (act !== exp_s) begin
        errors++;
        $display("FAIL random step=%0d instr=%h got=%h exp=%h", i, ins, act, exp_s);
      end
    end
  endtask

  initial begin
    valid_ID = 1'b0; instr_ID = '0; pc_ID = '0; rdata1_ID = '0; rdata2_ID = '0;
    stall = 1'b0; flush = 1'b0;
    exp_s = bubble(32'h0);
    test_reset;
    test_addi;
    test_branch_store;
    test_stall;
    test_flush_stall;
    test_illegal;
    test_async_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 Parameter: NOP_INSTR, 32'h0000_0013, instruction word recorded in instr_EX for a bubble.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 valid_ID  input  1  ID stage holds a real instruction.
REQ-005 instr_ID  input  32  instruction word in ID.
REQ-006 pc_ID  input  32  PC of the ID instruction.
REQ-007 rdata1_ID, rdata2_ID  input  32 each  register-file read data for rs1, rs2.
REQ-008 stall  input  1  hold EX registers (hazard unit).
REQ-009 flush  input  1  replace the EX contents with a bubble (branch/jump redirect).
REQ-010 valid_EX  output  1  EX holds a real instruction.
REQ-011 instr_EX, pc_EX  output  32 each  registered instruction and PC.
REQ-012 R1_EX, R2_EX  output  32 each  registered rs1/rs2 data; R2_EX feeds the forwarding path ahead of the ALU operand-B mux.
REQ-013 ImmExt_EX  output  32  registered sign-extended immediate, operand-B mux input 1.
REQ-014 Bsel  output  1  registered operand-B select: 1 = immediate, 0 = register.
REQ-015 rs1_EX, rs2_EX, rd_EX  output  5 each  registered register indices.
REQ-016 illegal_EX  output  1  EX instruction has an unsupported opcode.

Function
REQ-017 Immediate decode is combinational from instr_ID; the result is registered into ImmExt_EX with one-cycle latency (ID -> EX).
REQ-018 I-type (opcodes 0000011, 0010011, 1100111): imm = sign-extend of instr[31:20].
REQ-019 S-type (0100011): imm = sign-extend of {instr[31:25], instr[11:7]}.
REQ-020 B-type (1100011): imm = sign-extend of {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-021 U-type (0110111, 0010111): imm = {instr[31:12], 12'h000}.
REQ-022 J-type (1101111): imm = sign-extend of {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-023 R-type (0110011): imm = 0.
REQ-024 Bsel = 1 for opcodes 0000011, 0010011, 0100011, 0110111, 0010111, 1100111, 1101111; Bsel = 0 for 0110011 and 1100011.
REQ-025 Any other opcode: imm = 0, Bsel = 0, illegal = 1; the instruction still advances with valid_EX = valid_ID.
REQ-026 rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7]; rd_EX is forced to 0 for S-type and B-type (no write-back).
REQ-027 Normal cycle (flush=0, stall=0): all EX registers load the decoded ID values; valid_EX <= valid_ID.
REQ-028 When valid_ID = 0 and the stage is not stalled: load a bubble, same as REQ-030.
REQ-029 Stall (stall=1, flush=0): every EX register holds its value; ID inputs are ignored.
REQ-030 Flush (flush=1), including when stall=1 in the same cycle: load a bubble: valid_EX=0, instr_EX=NOP_INSTR, ImmExt_EX=0, Bsel=0, rd_EX=rs1_EX=rs2_EX=0, R1_EX=R2_EX=0, illegal_EX=0, pc_EX=pc_ID.
REQ-031 Priority: flush > stall > normal load.
REQ-032 Outputs change only on a clock edge or on reset assertion; there is no combinational path from any input to any output.

Reset
REQ-033 rst_n = 0 immediately (without waiting for a clock edge) forces the bubble values of REQ-030, with pc_EX = 0.
REQ-034 Reset asserted mid-stall or mid-flush overrides both; after rst_n deasserts, the first rising edge performs a normal load.

Verification
REQ-035 instr_ID=32'hFFF00093 (addi x1,x0,-1), valid_ID=1 -> next edge: ImmExt_EX=32'hFFFFFFFF, Bsel=1, rd_EX=1, valid_EX=1.
REQ-036 instr_ID=32'hFE208EE3 (beq x1,x2,-4) -> ImmExt_EX=32'hFFFFFFFC, Bsel=0, rd_EX=0; then instr_ID=32'h00112223 (sw x1,4(x2)) -> ImmExt_EX=4, Bsel=1, rd_EX=0.
REQ-037 Load add x3,x1,x2 (32'h002081B3), then hold stall=1 for 3 cycles while instr_ID changes -> all EX outputs unchanged (Bsel=0, rd_EX=3) for those 3 cycles.
REQ-038 flush=1 and stall=1 together with a valid lui in ID -> next edge: valid_EX=0, instr_EX=32'h00000013, Bsel=0, ImmExt_EX=0.
REQ-039 Opcode 7'b1111111 with valid_ID=1 -> illegal_EX=1, ImmExt_EX=0, Bsel=0, valid_EX=1.
REQ-040 rst_n driven low between clock edges while EX holds a valid instruction -> valid_EX=0, pc_EX=0, ImmExt_EX=0 before the next edge.
